vq_encoder: RTL and testbench
=============================

# vq_encoder

Vector-quantisation compressor: the encode-side counterpart of the decompress datapath. The block holds a 64-entry × 24-bit RGB codebook loaded over the `weight_*` write port. On `start`, it streams pixels out of the image RAM and, for each pixel, sequentially searches the codebook for the nearest codeword. It writes the winning 6-bit index into the tag RAM, which the decompressor later reads back through `tag_A` / `weight_A`.

## Interface
- `PIX_NUM`, default 65536: pixels per image; legal range 1..2^20.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse; begins encoding at pixel address 0.
- `weight_en`  in  1  codebook write strobe.
- `weight_A`  in  6  codebook entry index.
- `weight_data`  in  24  codeword {R[23:16], G[15:8], B[7:0]}.
- `RAM1_A`  out  20  image RAM read address (registered).
- `RAM1_Q`  in  24  image RAM read data; synchronous read, valid one cycle after the address is sampled.
- `tag_WE`  out  1  tag RAM write enable.
- `tag_A`  out  20  tag RAM write address (the pixel address).
- `tag_D`  out  6  tag RAM write data (the nearest codeword index).
- `state`  out  2  current state encoding.
- `busy`  out  1  high whenever `state` != IDLE.
- `done`  out  1  one-cycle pulse after the last tag write.

## Operation
- **States:** IDLE=00, FETCH=01, SEARCH=10, WRITE=11.
- **IDLE:**
  - `weight_en`=1 writes `weight_data` into `cb[weight_A]` at the clock edge.
  - `start`=1 clears `pix_addr` to 0 and moves to FETCH.
  - If both are asserted in the same cycle, both take effect; the written entry is visible to the first search.
- **FETCH:** lasts 2 cycles, tracked by an internal `fwait` bit.
  - Cycle 1: `RAM1_A`=`pix_addr`.
  - Cycle 2: `RAM1_Q` is captured into `pix` at the end of the cycle.
  - Then go to SEARCH with `idx`=0, `best_dist`=10'h3FF, `best_idx`=0.
- **SEARCH:** lasts 64 cycles, one codeword per cycle, `idx` = 0..63.
  - `dist` = |R−cR| + |G−cG| + |B−cB|.
  - Each channel difference is 8-bit unsigned; the sum is 10-bit unsigned, maximum 765, so no overflow is possible.
  - If `dist` < `best_dist` (strict), update `best_dist` and `best_idx`.
  - On a tie, the lowest index wins.
  - Entry 0 always updates, since 765 < 1023.
  - After `idx`=63 is evaluated, go to WRITE.
- **WRITE:** lasts 1 cycle.
  - `tag_WE`=1, `tag_A`=`pix_addr`, `tag_D`=`best_idx`.
  - If `pix_addr` == `PIX_NUM`−1: go to IDLE and pulse `done` in the next cycle.
  - Otherwise: `pix_addr`+1, then FETCH.
- **Ignored inputs:**
  - `weight_en` is ignored outside IDLE; the codebook is frozen during encode.
  - `start` is ignored outside IDLE.
- **Reset:**
  - All outputs and control registers go to 0 and the state goes to IDLE.
  - The codebook contents are NOT reset; they are retained across `rst`.
  - A reset mid-image abandons the image. `tag_WE` is 0 from the cycle after the reset edge, and `done` is not pulsed.
- **Uninitialised codebook:** entries never written since power-up are X in simulation. The bench must load all 64 entries before the first `start`.

## Timing
- **Reset values:** `RAM1_A`=0, `tag_WE`=0, `tag_A`=0, `tag_D`=0, `state`=00, `busy`=0, `done`=0.
- **Per-pixel latency:** 67 cycles = FETCH 2 + SEARCH 64 + WRITE 1.
- **Cycle numbering:** `start` is sampled at edge 0.
  - Cycles 1–2 are FETCH.
  - Cycles 3–66 are SEARCH.
  - Cycle 67 is the first `tag_WE`.
- **Pixel n:** `tag_WE` is high in cycle 67·(n+1).
- **Done:** `done` is high in cycle 67·`PIX_NUM`+1, and `state` is IDLE in that same cycle.
- **Restart:** a new `start` is accepted in the `done` cycle.
- **Output registration:** all outputs are registered. `tag_WE` is exactly 1 cycle wide, and `tag_A` / `tag_D` are stable while `tag_WE`=1.
- **Address order:** `tag_A` increments by exactly 1 between consecutive writes.

## Test plan
- **Reset:** assert `rst` for 3 cycles, with `start` held high during one of them → all outputs 0, `state`=00, no FETCH.
- **Nearest match:**
  - Setup: `cb[k]` = {4k, 4k, 4k} for k = 0..63; `PIX_NUM`=1; pixel 0 = 24'h111111.
  - Required: `tag_WE` in cycle 67 with `tag_D`=4 and `tag_A`=0; `done` in cycle 68.
- **Tie-break:**
  - Setup: `cb[3]` = `cb[5]` = 24'h808080, all other entries 0; pixel 24'h808080.
  - Required: `tag_D`=3.
- **Extremes:**
  - All-zero codebook, pixel 24'hFFFFFF → `tag_D`=0, with `dist` 765 not overflowing.
  - Set `cb[63]`=24'hFFFFFF → `tag_D`=63.
- **Multi-pixel run:**
  - Setup: `PIX_NUM`=4, pixels {k-matched codewords 10, 20, 30, 63}.
  - Required: writes in cycles 67/134/201/268 with `tag_A` 0..3 and `tag_D` 10/20/30/63; `done` in cycle 269.
- **Busy-time inputs and mid-run reset:**
  - During SEARCH, pulse `start` and write `cb[10]`=0 → run unaffected and `cb[10]` unchanged; verify on the next run.
  - Assert `rst` in cycle 100 → IDLE, no further `tag_WE`, no `done`; codebook intact on rerun.

Source files
------------

// File: rtl/vq_encoder.sv
// Vector-quantisation encoder: for each image pixel, sequentially scans a 64-entry RGB
// codebook for the minimum L1-distance codeword and writes its index to the tag RAM.
module vq_encoder #(
    parameter int PIX_NUM = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        weight_en,
    input  logic [5:0]  weight_A,
    input  logic [23:0] weight_data,
    output logic [19:0] RAM1_A,
    input  logic [23:0] RAM1_Q,
    output logic        tag_WE,
    output logic [19:0] tag_A,
    output logic [5:0]  tag_D,
    output logic [1:0]  state,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_FETCH  = 2'b01,
        S_SEARCH = 2'b10,
        S_WRITE  = 2'b11
    } state_t;

    localparam logic [19:0] LAST_ADDR = 20'(PIX_NUM - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_fwait;
    logic [19:0] r_pix_addr;
    logic [23:0] r_pix;
    logic [5:0]  r_idx;
    logic [5:0]  r_best_idx;
    logic [9:0]  r_best_dist;
    logic [23:0] r_cb [0:63];

    logic [23:0] w_cw;
    logic [9:0]  w_dist;
    logic        w_better;
    logic        w_last_pix;

    function automatic logic [9:0] absdiff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? {2'b00, a - b} : {2'b00, b - a};
    endfunction

    // Distance of the current pixel to the codeword under evaluation
    assign w_cw       = r_cb[r_idx];
    assign w_dist     = absdiff(r_pix[23:16], w_cw[23:16])
                      + absdiff(r_pix[15:8],  w_cw[15:8])
                      + absdiff(r_pix[7:0],   w_cw[7:0]);
    assign w_better   = (w_dist < r_best_dist);
    assign w_last_pix = (r_pix_addr == LAST_ADDR);
    assign state      = r_state;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start)          w_state_nxt = S_FETCH;
            S_FETCH:  if (r_fwait)        w_state_nxt = S_SEARCH;
            S_SEARCH: if (r_idx == 6'd63) w_state_nxt = S_WRITE;
            S_WRITE:  w_state_nxt = w_last_pix ? S_IDLE : S_FETCH;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Codebook survives reset and is frozen while an image is being encoded
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && weight_en)
            r_cb[weight_A] <= weight_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fwait    <= 1'b0;
            r_pix_addr <= '0;
            r_idx      <= '0;
            RAM1_A     <= '0;
            tag_WE     <= 1'b0;
            tag_A      <= '0;
            tag_D      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            busy   <= (w_state_nxt != S_IDLE);
            tag_WE <= 1'b0;
            done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_pix_addr <= '0;
                        RAM1_A     <= '0;
                        r_fwait    <= 1'b0;
                    end
                end
                S_FETCH: begin
                    r_fwait <= ~r_fwait;
                    if (r_fwait) r_idx <= '0;
                end
                S_SEARCH: begin
                    r_idx <= r_idx + 6'd1;
                    // Tag data must include the verdict on entry 63, evaluated this cycle
                    if (r_idx == 6'd63) begin
                        tag_WE <= 1'b1;
                        tag_A  <= r_pix_addr;
                        tag_D  <= w_better ? r_idx : r_best_idx;
                    end
                end
                S_WRITE: begin
                    if (w_last_pix) begin
                        done <= 1'b1;
                    end else begin
                        r_pix_addr <= r_pix_addr + 20'd1;
                        RAM1_A     <= r_pix_addr + 20'd1;
                        r_fwait    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pixel capture and running best-match datapath
    always_ff @(posedge clk) begin
        if (r_state == S_FETCH && r_fwait) begin
            r_pix       <= RAM1_Q;
            r_best_dist <= 10'h3FF;
            r_best_idx  <= '0;
        end else if (r_state == S_SEARCH && w_better) begin
            r_best_dist <= w_dist;
            r_best_idx  <= r_idx;
        end
    end

endmodule

// File: tb/tb_vq_encoder.sv
// Directed bench for vq_encoder: one single-pixel instance and one four-pixel instance.
module tb_vq_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start4, we1, we4;
    logic [5:0]  weight_A;
    logic [23:0] weight_data;

    logic [19:0] a1_RAM1_A, a4_RAM1_A, a1_tag_A, a4_tag_A;
    logic [23:0] q1, q4;
    logic        o1_tag_WE, o4_tag_WE, o1_busy, o4_busy, o1_done, o4_done;
    logic [5:0]  o1_tag_D, o4_tag_D;
    logic [1:0]  o1_state, o4_state;

    logic [23:0] ram1 [0:3];
    logic [23:0] ram4 [0:3];
    logic [23:0] cbv  [0:63];

    int errs = 0;
    int checks = 0;

    int n_wr, n_done;
    int wr_cyc [0:7];
    int wr_a   [0:7];
    int wr_d   [0:7];
    int done_cyc [0:1];
    logic [1:0]  st_log [0:511];
    logic        bz_log [0:511];
    logic [19:0] ra_log [0:511];

    always #5 clk = ~clk;

    vq_encoder #(.PIX_NUM(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .weight_en(we1), .weight_A(weight_A),
        .weight_data(weight_data), .RAM1_A(a1_RAM1_A), .RAM1_Q(q1), .tag_WE(o1_tag_WE),
        .tag_A(a1_tag_A), .tag_D(o1_tag_D), .state(o1_state), .busy(o1_busy), .done(o1_done)
    );

    vq_encoder #(.PIX_NUM(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .weight_en(we4), .weight_A(weight_A),
        .weight_data(weight_data), .RAM1_A(a4_RAM1_A), .RAM1_Q(q4), .tag_WE(o4_tag_WE),
        .tag_A(a4_tag_A), .tag_D(o4_tag_D), .state(o4_state), .busy(o4_busy), .done(o4_done)
    );

    always @(posedge clk) begin
        q1 <= ram1[a1_RAM1_A[1:0]];
        q4 <= ram4[a4_RAM1_A[1:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cb(input bit m1, input bit m4);
        for (int k = 0; k < 64; k++) begin
            weight_A    = 6'(k);
            weight_data = cbv[k];
            we1 = m1;
            we4 = m4;
            tick();
        end
        we1 = 1'b0;
        we4 = 1'b0;
    endtask

    task automatic set_cb_ramp();
        for (int k = 0; k < 64; k++) cbv[k] = {8'(4 * k), 8'(4 * k), 8'(4 * k)};
    endtask

    task automatic set_cb_zero();
        for (int k = 0; k < 64; k++) cbv[k] = 24'h0;
    endtask

    // Starts an image on the selected instance and logs its outputs for ncyc cycles.
    task automatic run(input bit sel4, input int ncyc, input int rst_at, input int poke_at,
                       input bit restart, input bit wr_start, input logic [5:0] wa,
                       input logic [23:0] wd);
        n_wr = 0;
        n_done = 0;
        done_cyc[0] = -1;
        done_cyc[1] = -1;
        if (sel4) start4 = 1'b1; else start1 = 1'b1;
        if (wr_start) begin
            weight_A = wa;
            weight_data = wd;
            if (sel4) we4 = 1'b1; else we1 = 1'b1;
        end
        tick();
        start1 = 1'b0; start4 = 1'b0; we1 = 1'b0; we4 = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            if (c < 512) begin
                st_log[c] = sel4 ? o4_state : o1_state;
                bz_log[c] = sel4 ? o4_busy : o1_busy;
                ra_log[c] = sel4 ? a4_RAM1_A : a1_RAM1_A;
            end
            if (sel4 ? o4_tag_WE : o1_tag_WE) begin
                if (n_wr < 8) begin
                    wr_cyc[n_wr] = c;
                    wr_a[n_wr]   = int'(sel4 ? a4_tag_A : a1_tag_A);
                    wr_d[n_wr]   = int'(sel4 ? o4_tag_D : o1_tag_D);
                end
                n_wr++;
            end
            if (sel4 ? o4_done : o1_done) begin
                if (n_done < 2) done_cyc[n_done] = c;
                n_done++;
                if (restart && n_done == 1) begin
                    if (sel4) start4 = 1'b1; else start1 = 1'b1;
                end
            end
            rst = (c == rst_at);
            if (c == poke_at) begin
                weight_A = 6'd10;
                weight_data = 24'h0;
                if (sel4) begin start4 = 1'b1; we4 = 1'b1; end
                else      begin start1 = 1'b1; we1 = 1'b1; end
            end
            tick();
            rst = 1'b0; start1 = 1'b0; start4 = 1'b0; we1 = 1'b0; we4 = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        start1 = 1'b1; start4 = 1'b1;
        tick();
        start1 = 1'b0; start4 = 1'b0;
        tick();
        rst = 1'b0;
        checks++;
        if ({a1_RAM1_A, o1_tag_WE, a1_tag_A, o1_tag_D, o1_state, o1_busy, o1_done} !== '0) begin
            errs++;
            $display("FAIL reset_outputs_dut1: got RAM1_A=%h WE=%b A=%h D=%h st=%b busy=%b done=%b, want all 0",
                     a1_RAM1_A, o1_tag_WE, a1_tag_A, o1_tag_D, o1_state, o1_busy, o1_done);
        end
        checks++;
        if ({a4_RAM1_A, o4_tag_WE, a4_tag_A, o4_tag_D, o4_state, o4_busy, o4_done} !== '0) begin
            errs++;
            $display("FAIL reset_outputs_dut4: got RAM1_A=%h WE=%b A=%h D=%h st=%b busy=%b done=%b, want all 0",
                     a4_RAM1_A, o4_tag_WE, a4_tag_A, o4_tag_D, o4_state, o4_busy, o4_done);
        end
        tick();
        tick();
        checks++;
        if ({o1_state, o1_busy, o4_state, o4_busy} !== 6'b0) begin
            errs++;
            $display("FAIL reset_no_fetch: got st1=%b busy1=%b st4=%b busy4=%b, want IDLE/0",
                     o1_state, o1_busy, o4_state, o4_busy);
        end
    endtask

    task automatic test_nearest_match();
        set_cb_ramp();
        load_cb(1'b1, 1'b0);
        ram1[0] = 24'h111111;
        run(1'b0, 140, 0, 0, 1'b1, 1'b0, 6'd0, 24'h0);
        checks++;
        if (n_wr !== 2 || wr_cyc[0] !== 67 || wr_a[0] !== 0 || wr_d[0] !== 4) begin
            errs++;
            $display("FAIL nearest_write: got n=%0d cyc=%0d A=%0d D=%0d, want n=2 cyc=67 A=0 D=4",
                     n_wr, wr_cyc[0], wr_a[0], wr_d[0]);
        end
        checks++;
        if (done_cyc[0] !== 68 || st_log[68] !== 2'b00) begin
            errs++;
            $display("FAIL nearest_done: got done_cyc=%0d state=%b, want 68 / 00", done_cyc[0], st_log[68]);
        end
        checks++;
        if (st_log[1] !== 2'b01 || st_log[2] !== 2'b01 || st_log[3] !== 2'b10 ||
            st_log[67] !== 2'b11 || bz_log[1] !== 1'b1 || bz_log[68] !== 1'b0) begin
            errs++;
            $display("FAIL nearest_states: got st1=%b st2=%b st3=%b st67=%b busy1=%b busy68=%b, want 01 01 10 11 1 0",
                     st_log[1], st_log[2], st_log[3], st_log[67], bz_log[1], bz_log[68]);
        end
        checks++;
        if (wr_cyc[1] !== 135 || wr_d[1] !== 4 || done_cyc[1] !== 136) begin
            errs++;
            $display("FAIL restart_in_done: got wr=%0d D=%0d done=%0d, want 135 4 136",
                     wr_cyc[1], wr_d[1], done_cyc[1]);
        end
    endtask

    task automatic test_tie_break();
        set_cb_zero();
        cbv[3] = 24'h808080;
        cbv[5] = 24'h808080;
        load_cb(1'b1, 1'b0);
        ram1[0] = 24'h808080;
        run(1'b0, 70, 0, 0, 1'b0, 1'b0, 6'd0, 24'h0);
        checks++;
        if (n_wr !== 1 || wr_d[0] !== 3) begin
            errs++;
            $display("FAIL tie_break: got n=%0d D=%0d, want n=1 D=3", n_wr, wr_d[0]);
        end
    endtask

    task automatic test_extremes();
        set_cb_zero();
        load_cb(1'b1, 1'b0);
        ram1[0] = 24'hFFFFFF;
        run(1'b0, 70, 0, 0, 1'b0, 1'b0, 6'd0, 24'h0);
        checks++;
        if (n_wr !== 1 || wr_d[0] !== 0) begin
            errs++;
            $display("FAIL extreme_zero_cb: got n=%0d D=%0d, want n=1 D=0", n_wr, wr_d[0]);
        end
        // cb[63] written in the same cycle as start must be seen by the search
        run(1'b0, 70, 0, 0, 1'b0, 1'b1, 6'd63, 24'hFFFFFF);
        checks++;
        if (n_wr !== 1 || wr_d[0] !== 63) begin
            errs++;
            $display("FAIL extreme_cb63: got n=%0d D=%0d, want n=1 D=63", n_wr, wr_d[0]);
        end
    endtask

    task automatic check_multi(input string tag);
        int exp_d [0:3];
        exp_d[0] = 10; exp_d[1] = 20; exp_d[2] = 30; exp_d[3] = 63;
        checks++;
        if (n_wr !== 4) begin
            errs++;
            $display("FAIL %s_count: got %0d writes, want 4", tag, n_wr);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_cyc[i] !== 67 * (i + 1) || wr_a[i] !== i || wr_d[i] !== exp_d[i]) begin
                errs++;
                $display("FAIL %s_write%0d: got cyc=%0d A=%0d D=%0d, want cyc=%0d A=%0d D=%0d",
                         tag, i, wr_cyc[i], wr_a[i], wr_d[i], 67 * (i + 1), i, exp_d[i]);
            end
        end
        checks++;
        if (n_done !== 1 || done_cyc[0] !== 269 || st_log[269] !== 2'b00) begin
            errs++;
            $display("FAIL %s_done: got n=%0d cyc=%0d st=%b, want 1 269 00",
                     tag, n_done, done_cyc[0], st_log[269]);
        end
    endtask

    task automatic test_multi_pixel();
        set_cb_ramp();
        load_cb(1'b0, 1'b1);
        ram4[0] = 24'h282828;
        ram4[1] = 24'h505050;
        ram4[2] = 24'h787878;
        ram4[3] = 24'hFCFCFC;
        run(1'b1, 280, 0, 0, 1'b0, 1'b0, 6'd0, 24'h0);
        check_multi("multi");
        checks++;
        if (ra_log[1] !== 20'd0 || ra_log[68] !== 20'd1 || ra_log[202] !== 20'd3) begin
            errs++;
            $display("FAIL multi_ram_addr: got %0d %0d %0d, want 0 1 3", ra_log[1], ra_log[68], ra_log[202]);
        end
    endtask

    task automatic test_busy_inputs();
        run(1'b1, 280, 0, 10, 1'b0, 1'b0, 6'd0, 24'h0);
        check_multi("busy_poke");
        run(1'b1, 70, 0, 0, 1'b0, 1'b0, 6'd0, 24'h0);
        checks++;
        if (n_wr !== 1 || wr_d[0] !== 10) begin
            errs++;
            $display("FAIL busy_cb10_kept: got n=%0d D=%0d, want n=1 D=10", n_wr, wr_d[0]);
        end
        // Finish the partial image so the instance is idle again
        for (int c = 71; c <= 280; c++) tick();
    endtask

    task automatic test_mid_reset();
        run(1'b1, 300, 100, 0, 1'b0, 1'b0, 6'd0, 24'h0);
        checks++;
        if (n_wr !== 1 || wr_cyc[0] !== 67 || n_done !== 0) begin
            errs++;
            $display("FAIL mid_reset_abandon: got writes=%0d first=%0d dones=%0d, want 1 67 0",
                     n_wr, wr_cyc[0], n_done);
        end
        checks++;
        if (st_log[101] !== 2'b00 || bz_log[101] !== 1'b0 || st_log[300] !== 2'b00) begin
            errs++;
            $display("FAIL mid_reset_idle: got st101=%b busy101=%b st300=%b, want 00 0 00",
                     st_log[101], bz_log[101], st_log[300]);
        end
        run(1'b1, 280, 0, 0, 1'b0, 1'b0, 6'd0, 24'h0);
        check_multi("after_reset");
    endtask

    initial begin
        rst = 1'b1;
        start1 = 1'b0; start4 = 1'b0; we1 = 1'b0; we4 = 1'b0;
        weight_A = '0; weight_data = '0;
        for (int i = 0; i < 4; i++) begin ram1[i] = 24'h0; ram4[i] = 24'h0; end
        tick();
        test_reset();
        test_nearest_match();
        test_tie_break();
        test_extremes();
        test_multi_pixel();
        test_busy_inputs();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
